zmod_rxclk_ctrl: RTL and testbench
==================================

Name: zmod_rxclk_ctrl

Overview:
Bring-up and phase controller for the ZMOD RX clock MMCM. It sequences the MMCM reset, qualifies LOCKED, and retries on lock timeout. It then steps the MMCM dynamic phase shift (PSEN/PSINCDEC/PSDONE) to a host-requested signed step count. It runs on the free-running control clock, which also drives the MMCM PSCLK, and never on an MMCM output.

Parameters:
RST_CYCLES, 16, cycles mmcm_rst is held high per attempt
LOCK_STABLE, 1024, consecutive synced-lock cycles required before ready
LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before a retry
MAX_RETRIES, 3, retries after the first attempt before fault
PS_W, 10, width of signed phase step count
PSDONE_TIMEOUT, 64, cycles allowed for psdone after a psen pulse

Ports:
clk  in  1  control clock; also MMCM PSCLK
rstn  in  1  synchronous active-low reset
restart  in  1  pulse; restarts the bring-up sequence from any state
mmcm_locked  in  1  MMCM LOCKED, asynchronous; 2-flop synchronized inside
mmcm_rst  out  1  MMCM RST
mmcm_psen  out  1  MMCM PSEN, one-cycle pulse
mmcm_psincdec  out  1  MMCM PSINCDEC: 1 = increment, 0 = decrement
mmcm_psdone  in  1  MMCM PSDONE, synchronous to clk
phase_req  in  1  level; request a move to phase_target
phase_target  in  PS_W  signed target step count
phase_ack  out  1  one-cycle pulse; request complete
phase_err  out  1  valid with phase_ack; 1 = aborted
phase_cur  out  PS_W  signed current applied step count
ready  out  1  MMCM locked and qualified
fault  out  1  sticky failure
lock_lost  out  1  one-cycle pulse on lock loss after qualification
retry_cnt  out  $clog2(MAX_RETRIES+1)  attempts used

Behaviour:
- Reset (rstn=0 at a clk edge) puts the block in RESET_HOLD and sets:
  - mmcm_rst=1; mmcm_psen=0; mmcm_psincdec=0
  - phase_ack=0; phase_err=0; phase_cur=0
  - ready=0; fault=0; lock_lost=0; retry_cnt=0; all timers 0
- locked_s = mmcm_locked after 2 flops (2-cycle latency). Only locked_s is used.
- RESET_HOLD: mmcm_rst=1 for exactly RST_CYCLES cycles, then mmcm_rst=0 and go to WAIT_LOCK with the timer cleared.
- WAIT_LOCK:
  - locked_s=1 -> STABLE, counter cleared.
  - Timer reaches LOCK_TIMEOUT-1:
    - retry_cnt==MAX_RETRIES -> FAULT.
    - Otherwise retry_cnt+1 and go to RESET_HOLD.
- STABLE:
  - locked_s=0 -> WAIT_LOCK; the timeout timer restarts and no retry is consumed.
  - LOCK_STABLE consecutive high cycles -> READY, ready=1 on the next cycle.
- READY:
  - phase_req=1 latches phase_target into tgt.
  - If tgt==phase_cur: phase_ack=1, phase_err=0 on the next cycle; stay in READY.
  - Otherwise go to PS_ISSUE.
  - phase_req must drop after phase_ack. A req still high on the cycle after ack starts a new request.
- PS_ISSUE: mmcm_psen=1 for one cycle, mmcm_psincdec=(tgt>phase_cur, signed compare), then go to PS_WAIT. mmcm_psincdec holds its value until the next issue.
- PS_WAIT:
  - On mmcm_psdone, phase_cur moves ±1.
  - If the new phase_cur==tgt: phase_ack pulse, go to READY.
  - Otherwise go to PS_ISSUE. There is at least one idle cycle between psen pulses.
  - PSDONE_TIMEOUT cycles with no psdone -> FAULT with phase_ack=1, phase_err=1.
- phase_target changes after latching are ignored until the next request. phase_cur wraps in two's complement; no saturation.
- Lock loss (locked_s=0) in READY, PS_ISSUE or PS_WAIT:
  - lock_lost pulse; ready=0; phase_cur=0.
  - Any in-flight request gets phase_ack=1, phase_err=1.
  - Go to RESET_HOLD. retry_cnt is unchanged.
- FAULT:
  - mmcm_rst=1; ready=0; fault=1; psen=0.
  - phase_req is ignored.
  - Exit only via rstn or restart.
- restart=1 in any state:
  - Go to RESET_HOLD on the next cycle and clear fault, retry_cnt and phase_cur.
  - An in-flight request gets an error ack.
- Priority per cycle: rstn > restart > lock loss > psdone/timeout > phase_req.
- psdone outside PS_WAIT is ignored.

Test Plan:
Use RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_RETRIES=2, PSDONE_TIMEOUT=16, PS_W=10. The MMCM model asserts psdone 3 cycles after psen.
- Nominal bring-up: after rstn rises, assert locked 10 cycles later -> mmcm_rst high for exactly 4 cycles; ready rises 2+8(+1) cycles after the locked edge; retry_cnt=0.
- Lock never asserts -> 3 attempts (retry_cnt 0,1,2), each with a 4-cycle mmcm_rst pulse; fault=1 after the third timeout; mmcm_rst stays 1; restart pulse -> fault=0 and the sequence restarts.
- From READY, phase_target=+5 -> 5 psen pulses with psincdec=1; phase_cur steps 1..5; one phase_ack with phase_err=0. Then target=-2 -> 7 pulses with psincdec=0; phase_cur=-2.
- Target equal to phase_cur -> phase_ack the next cycle; no psen pulse.
- Drop locked during PS_WAIT after 2 of 5 steps -> lock_lost pulse; phase_ack with phase_err=1; phase_cur=0; RESET_HOLD entered; retry_cnt unchanged.
- psdone withheld -> FAULT after 16 cycles with phase_err=1. Also check that restart and locked drop on the same cycle take the restart path, with no lock_lost pulse.

Source files
------------

// File: rtl/zmod_rxclk_ctrl.sv
// zmod_rxclk_ctrl: bring-up and dynamic phase controller for the ZMOD RX clock MMCM.
// Runs entirely on the free-running control clock (which also feeds MMCM PSCLK).
// It sequences MMCM reset and qualifies LOCKED. It retries on lock timeout, then
// steps the phase shifter one PSEN pulse at a time toward a host-requested signed
// step count.
module zmod_rxclk_ctrl #(
  parameter int RST_CYCLES     = 16,
  parameter int LOCK_STABLE    = 1024,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int MAX_RETRIES    = 3,
  parameter int PS_W           = 10,
  parameter int PSDONE_TIMEOUT = 64
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             restart,
  input  logic                             mmcm_locked,
  output logic                             mmcm_rst,
  output logic                             mmcm_psen,
  output logic                             mmcm_psincdec,
  input  logic                             mmcm_psdone,
  input  logic                             phase_req,
  input  logic [PS_W-1:0]                  phase_target,
  output logic                             phase_ack,
  output logic                             phase_err,
  output logic [PS_W-1:0]                  phase_cur,
  output logic                             ready,
  output logic                             fault,
  output logic                             lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt
);

  localparam int RC_W    = $clog2(MAX_RETRIES + 1);
  localparam int M1      = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int M2      = (LOCK_TIMEOUT > PSDONE_TIMEOUT) ? LOCK_TIMEOUT : PSDONE_TIMEOUT;
  localparam int TMR_MAX = (M1 > M2) ? M1 : M2;
  // One shared timer; it only ever counts up to (longest interval - 1).
  localparam int TMR_W   = $clog2(TMR_MAX);

  localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(LOCK_STABLE - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] PSD_LAST    = TMR_W'(PSDONE_TIMEOUT - 1);
  localparam logic [RC_W-1:0]  RETRY_LAST  = RC_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_HOLD,
    S_WAIT_LOCK,
    S_STABLE,
    S_READY,
    S_PS_ISSUE,
    S_PS_WAIT,
    S_FAULT
  } state_t;

  state_t                  state_q, state_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [RC_W-1:0]         retry_q, retry_d;
  logic signed [PS_W-1:0]  tgt_q, tgt_d;
  logic signed [PS_W-1:0]  cur_q, cur_d;
  logic                    incdec_q, incdec_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    lost_q, lost_d;
  logic                    lk_meta_q, lk_sync_q;

  logic                    locked_s;
  logic                    inflight;
  logic signed [PS_W-1:0]  tgt_in;
  logic signed [PS_W-1:0]  cur_step;

  // One phase step in the direction last issued; wraps in two's complement.
  function automatic logic signed [PS_W-1:0] step_phase(input logic signed [PS_W-1:0] c,
                                                        input logic                   up);
    return up ? (c + PS_W'(1)) : (c - PS_W'(1));
  endfunction

  assign locked_s = lk_sync_q;
  assign inflight = (state_q == S_PS_ISSUE) || (state_q == S_PS_WAIT);
  assign tgt_in   = phase_target;

  // Next-state and control decisions, in priority order restart > lock loss > per-state.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    retry_d  = retry_q;
    tgt_d    = tgt_q;
    cur_d    = cur_q;
    incdec_d = incdec_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    lost_d   = 1'b0;
    cur_step = step_phase(cur_q, incdec_q);

    if (restart) begin
      state_d = S_RESET_HOLD;
      timer_d = '0;
      retry_d = '0;
      cur_d   = '0;
      ack_d   = inflight;
      err_d   = inflight;
    end else if (!locked_s && ((state_q == S_READY) || inflight)) begin
      // Lock dropped after qualification: the applied phase is lost with the lock.
      state_d = S_RESET_HOLD;
      timer_d = '0;
      cur_d   = '0;
      lost_d  = 1'b1;
      ack_d   = inflight;
      err_d   = inflight;
    end else begin
      case (state_q)
        S_RESET_HOLD: begin
          if (timer_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = S_STABLE;
            timer_d = '0;
          end else if (timer_q == LOCK_LAST) begin
            timer_d = '0;
            if (retry_q == RETRY_LAST) begin
              state_d = S_FAULT;
            end else begin
              retry_d = retry_q + 1'b1;
              state_d = S_RESET_HOLD;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_STABLE: begin
          // A glitch only restarts the lock wait; it does not burn a retry.
          if (!locked_s) begin
            state_d = S_WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q == STABLE_LAST) begin
            state_d = S_READY;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_READY: begin
          if (phase_req) begin
            tgt_d = tgt_in;
            if (tgt_in == cur_q) begin
              ack_d = 1'b1;
            end else begin
              state_d  = S_PS_ISSUE;
              incdec_d = (tgt_in > cur_q);
            end
          end
        end
        S_PS_ISSUE: begin
          state_d = S_PS_WAIT;
          timer_d = '0;
        end
        S_PS_WAIT: begin
          if (mmcm_psdone) begin
            cur_d   = cur_step;
            timer_d = '0;
            if (cur_step == tgt_q) begin
              state_d = S_READY;
              ack_d   = 1'b1;
            end else begin
              state_d  = S_PS_ISSUE;
              incdec_d = (tgt_q > cur_step);
            end
          end else if (timer_q == PSD_LAST) begin
            state_d = S_FAULT;
            timer_d = '0;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_RESET_HOLD;
          timer_d = '0;
        end
      endcase
    end
  end

  // State, timers, phase bookkeeping and the two-flop LOCKED synchronizer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_RESET_HOLD;
      timer_q   <= '0;
      retry_q   <= '0;
      tgt_q     <= '0;
      cur_q     <= '0;
      incdec_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      lost_q    <= 1'b0;
      lk_meta_q <= 1'b0;
      lk_sync_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      tgt_q     <= tgt_d;
      cur_q     <= cur_d;
      incdec_q  <= incdec_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      lost_q    <= lost_d;
      lk_meta_q <= mmcm_locked;
      lk_sync_q <= lk_meta_q;
    end
  end

  assign mmcm_rst      = (state_q == S_RESET_HOLD) || (state_q == S_FAULT);
  assign mmcm_psen     = (state_q == S_PS_ISSUE);
  assign mmcm_psincdec = incdec_q;
  assign phase_ack     = ack_q;
  assign phase_err     = err_q;
  assign phase_cur     = cur_q;
  assign ready         = (state_q == S_READY) || inflight;
  assign fault         = (state_q == S_FAULT);
  assign lock_lost     = lost_q;
  assign retry_cnt     = retry_q;

endmodule

// File: tb/tb_zmod_rxclk_ctrl.sv
// Bench for zmod_rxclk_ctrl: scenario tasks driven from one initial block, with an
// MMCM phase-shift model answering psdone three cycles after each psen.
module tb_zmod_rxclk_ctrl;

  localparam int RSTC = 4;
  localparam int LSTB = 8;
  localparam int LTMO = 32;
  localparam int MRET = 2;
  localparam int PSW  = 10;
  localparam int PTMO = 16;

  logic           clk = 1'b0;
  logic           rstn, restart, mmcm_locked, mmcm_psdone, phase_req;
  logic [PSW-1:0] phase_target;
  logic           mmcm_rst, mmcm_psen, mmcm_psincdec;
  logic           phase_ack, phase_err, ready, fault, lock_lost;
  logic [PSW-1:0] phase_cur;
  logic [1:0]     retry_cnt;

  int n_chk = 0;
  int n_pass = 0;

  int psen_cnt, inc_cnt, ack_cnt, err_cnt, lost_cnt, gap_bad, since_psen;
  int model_cur;
  logic [3:0] pd_pipe;
  bit withhold;
  int cur_hist[$];
  logic [PSW-1:0] prev_cur;

  zmod_rxclk_ctrl #(
    .RST_CYCLES(RSTC), .LOCK_STABLE(LSTB), .LOCK_TIMEOUT(LTMO),
    .MAX_RETRIES(MRET), .PS_W(PSW), .PSDONE_TIMEOUT(PTMO)
  ) dut (
    .clk(clk), .rstn(rstn), .restart(restart), .mmcm_locked(mmcm_locked),
    .mmcm_rst(mmcm_rst), .mmcm_psen(mmcm_psen), .mmcm_psincdec(mmcm_psincdec),
    .mmcm_psdone(mmcm_psdone), .phase_req(phase_req), .phase_target(phase_target),
    .phase_ack(phase_ack), .phase_err(phase_err), .phase_cur(phase_cur),
    .ready(ready), .fault(fault), .lock_lost(lock_lost), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  function automatic int cur_i();
    return int'($signed(phase_cur));
  endfunction

  // Advance one cycle, sample 1ns after the edge, update monitors and the MMCM model.
  task automatic tick();
    @(posedge clk);
    #1;
    since_psen++;
    if (mmcm_psen) begin
      psen_cnt++;
      if (mmcm_psincdec) inc_cnt++;
      if (since_psen < 2) gap_bad++;
      since_psen = 0;
    end
    if (phase_ack) begin
      ack_cnt++;
      if (phase_err) err_cnt++;
    end
    if (lock_lost) lost_cnt++;
    if (phase_cur !== prev_cur) begin
      cur_hist.push_back(cur_i());
      prev_cur = phase_cur;
    end
    pd_pipe = {pd_pipe[2:0], mmcm_psen & ~withhold};
    mmcm_psdone = pd_pipe[3];
  endtask

  task automatic clr_counts();
    psen_cnt = 0; inc_cnt = 0; ack_cnt = 0; err_cnt = 0; lost_cnt = 0;
    cur_hist.delete();
  endtask

  task automatic reset_dut();
    rstn = 1'b0; restart = 1'b0; mmcm_locked = 1'b0; phase_req = 1'b0;
    phase_target = '0; withhold = 1'b0; pd_pipe = '0; mmcm_psdone = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    model_cur = 0;
    clr_counts();
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    while (!ready && n < budget) begin
      tick();
      n++;
    end
  endtask

  // Request a move and hold phase_req until the ack; the target input is scrambled
  // after the first edge to show only the latched value matters.
  task automatic move(input int tgt, output bit to, output int n);
    phase_target = PSW'(tgt);
    phase_req = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) phase_target = PSW'($urandom);
    end while (!phase_ack && n < 300);
    to = !phase_ack;
    phase_req = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    restart = 1'($urandom); mmcm_locked = 1'($urandom); phase_req = 1'($urandom);
    phase_target = PSW'($urandom); mmcm_psdone = 1'($urandom);
    withhold = 1'b0; pd_pipe = '0;
    repeat (3) tick();
    n_chk++;
    if ({mmcm_rst, mmcm_psen, mmcm_psincdec, phase_ack, phase_err, ready, fault, lock_lost} !== 8'b1000_0000
        || phase_cur !== '0 || retry_cnt !== 2'd0)
      $display("FAIL reset_state: rst=%b psen=%b incdec=%b ack=%b err=%b rdy=%b flt=%b lost=%b cur=%0d retry=%0d, required rst=1 others 0",
               mmcm_rst, mmcm_psen, mmcm_psincdec, phase_ack, phase_err, ready, fault, lock_lost, cur_i(), retry_cnt);
    else n_pass++;
  endtask

  task automatic test_bringup();
    int rst_hi, n;
    reset_dut();
    rst_hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (mmcm_rst) rst_hi++;
      tick();
    end
    mmcm_locked = 1'b1;
    n = 0;
    while (!ready && n < 60) begin
      if (mmcm_rst) rst_hi++;
      tick();
      n++;
    end
    n_chk++;
    if (rst_hi != RSTC) $display("FAIL bringup_rst_width: got %0d cycles, required %0d", rst_hi, RSTC);
    else n_pass++;
    n_chk++;
    if (n != 2 + LSTB + 1) $display("FAIL bringup_ready_latency: got %0d cycles, required %0d", n, 2 + LSTB + 1);
    else n_pass++;
    n_chk++;
    if (retry_cnt !== 2'd0 || fault !== 1'b0 || mmcm_rst !== 1'b0)
      $display("FAIL bringup_status: retry=%0d fault=%b rst=%b, required 0 0 0", retry_cnt, fault, mmcm_rst);
    else n_pass++;
  endtask

  task automatic test_lock_timeout();
    int s, run_len, n;
    bit prev_rst;
    int lens[$];
    int rcs[$];
    reset_dut();
    s = 0; run_len = 0; prev_rst = 1'b0;
    while (!fault && s < 400) begin
      if (mmcm_rst && !prev_rst) begin
        rcs.push_back(int'(retry_cnt));
        run_len = 0;
      end
      if (mmcm_rst) run_len++;
      if (!mmcm_rst && prev_rst) lens.push_back(run_len);
      prev_rst = mmcm_rst;
      tick();
      s++;
    end
    n_chk++;
    if (s != (MRET + 1) * (RSTC + LTMO))
      $display("FAIL timeout_fault_time: got %0d cycles, required %0d", s, (MRET + 1) * (RSTC + LTMO));
    else n_pass++;
    n_chk++;
    if (lens.size() != MRET + 1 || rcs.size() != MRET + 1)
      $display("FAIL timeout_attempts: got %0d pulses, required %0d", lens.size(), MRET + 1);
    else n_pass++;
    for (int i = 0; i < lens.size() && i < rcs.size(); i++) begin
      n_chk++;
      if (lens[i] != RSTC || rcs[i] != i)
        $display("FAIL timeout_attempt_%0d: width %0d retry %0d, required width %0d retry %0d", i, lens[i], rcs[i], RSTC, i);
      else n_pass++;
    end
    // FAULT ignores phase requests and keeps the MMCM in reset.
    clr_counts();
    phase_target = PSW'(7);
    phase_req = 1'b1;
    repeat (6) tick();
    phase_req = 1'b0;
    n_chk++;
    if (fault !== 1'b1 || mmcm_rst !== 1'b1 || ready !== 1'b0 || psen_cnt != 0 || ack_cnt != 0 || retry_cnt !== 2'(MRET))
      $display("FAIL fault_hold: fault=%b rst=%b ready=%b psen=%0d ack=%0d retry=%0d, required 1 1 0 0 0 %0d",
               fault, mmcm_rst, ready, psen_cnt, ack_cnt, retry_cnt, MRET);
    else n_pass++;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n_chk++;
    if (fault !== 1'b0 || retry_cnt !== 2'd0 || mmcm_rst !== 1'b1)
      $display("FAIL restart_from_fault: fault=%b retry=%0d rst=%b, required 0 0 1", fault, retry_cnt, mmcm_rst);
    else n_pass++;
    n = 0;
    while (mmcm_rst && n < 20) begin
      tick();
      n++;
    end
    n_chk++;
    if (n != RSTC) $display("FAIL restart_rst_width: got %0d, required %0d", n, RSTC);
    else n_pass++;
  endtask

  task automatic bring_ready();
    int n;
    reset_dut();
    repeat (2) tick();
    mmcm_locked = 1'b1;
    wait_ready(80, n);
    n_chk++;
    if (ready !== 1'b1) $display("FAIL bring_ready: ready=%b after %0d cycles, required 1", ready, n);
    else n_pass++;
  endtask

  task automatic check_move(input string nm, input int tgt);
    bit to;
    int n, exp_p, exp_inc;
    bit ramp_ok;
    exp_p = (tgt > model_cur) ? tgt - model_cur : model_cur - tgt;
    exp_inc = (tgt > model_cur) ? exp_p : 0;
    clr_counts();
    move(tgt, to, n);
    tick();
    ramp_ok = (cur_hist.size() == exp_p);
    for (int i = 0; i < cur_hist.size() && ramp_ok; i++)
      if (cur_hist[i] != model_cur + ((tgt > model_cur) ? i + 1 : -(i + 1))) ramp_ok = 1'b0;
    n_chk++;
    if (to || psen_cnt != exp_p || inc_cnt != exp_inc)
      $display("FAIL %s_pulses: timeout=%b psen=%0d inc=%0d, required 0 %0d %0d", nm, to, psen_cnt, inc_cnt, exp_p, exp_inc);
    else n_pass++;
    n_chk++;
    if (cur_i() != tgt || !ramp_ok)
      $display("FAIL %s_phase: cur=%0d steps=%0d, required %0d via %0d unit steps", nm, cur_i(), cur_hist.size(), tgt, exp_p);
    else n_pass++;
    n_chk++;
    if (ack_cnt != 1 || err_cnt != 0)
      $display("FAIL %s_ack: acks=%0d errs=%0d, required 1 0", nm, ack_cnt, err_cnt);
    else n_pass++;
    model_cur = tgt;
  endtask

  task automatic test_phase_steps();
    bring_ready();
    check_move("step_up5", 5);
    check_move("step_dn2", -2);
  endtask

  task automatic test_equal_target();
    bit to;
    int n;
    clr_counts();
    move(model_cur, to, n);
    n_chk++;
    if (to || n != 1 || phase_err !== 1'b0)
      $display("FAIL equal_ack: timeout=%b latency=%0d err=%b, required 0 1 0", to, n, phase_err);
    else n_pass++;
    repeat (3) tick();
    n_chk++;
    if (psen_cnt != 0 || ack_cnt != 1 || cur_i() != model_cur)
      $display("FAIL equal_nopsen: psen=%0d acks=%0d cur=%0d, required 0 1 %0d", psen_cnt, ack_cnt, cur_i(), model_cur);
    else n_pass++;
  endtask

  task automatic test_random_moves();
    gap_bad = 0;
    for (int k = 0; k < 6; k++) begin
      check_move("rand_move", int'($urandom_range(40)) - 20);
      repeat ($urandom_range(3)) tick();
    end
    n_chk++;
    if (gap_bad != 0) $display("FAIL psen_spacing: %0d back-to-back pulses, required 0", gap_bad);
    else n_pass++;
  endtask

  task automatic test_lock_loss();
    int n, start, mid;
    start = model_cur;
    clr_counts();
    phase_target = PSW'(start + 5);
    phase_req = 1'b1;
    n = 0;
    while (psen_cnt < 3 && n < 100) begin
      tick();
      n++;
    end
    mid = cur_i();
    mmcm_locked = 1'b0;
    n = 0;
    while (!lock_lost && n < 20) begin
      tick();
      n++;
    end
    n_chk++;
    if (mid != start + 2) $display("FAIL lockloss_progress: cur=%0d at third psen, required %0d", mid, start + 2);
    else n_pass++;
    n_chk++;
    if (n != 3) $display("FAIL lockloss_latency: got %0d cycles, required 3", n);
    else n_pass++;
    n_chk++;
    if (phase_ack !== 1'b1 || phase_err !== 1'b1 || phase_cur !== '0 || ready !== 1'b0 || mmcm_rst !== 1'b1 || retry_cnt !== 2'd0)
      $display("FAIL lockloss_state: ack=%b err=%b cur=%0d ready=%b rst=%b retry=%0d, required 1 1 0 0 1 0",
               phase_ack, phase_err, cur_i(), ready, mmcm_rst, retry_cnt);
    else n_pass++;
    phase_req = 1'b0;
    repeat (3) tick();
    n_chk++;
    if (lost_cnt != 1 || ack_cnt != 1) $display("FAIL lockloss_pulses: lost=%0d acks=%0d, required 1 1", lost_cnt, ack_cnt);
    else n_pass++;
    model_cur = 0;
    mmcm_locked = 1'b1;
    wait_ready(80, n);
    n_chk++;
    if (ready !== 1'b1 || retry_cnt !== 2'd0) $display("FAIL relock: ready=%b retry=%0d, required 1 0", ready, retry_cnt);
    else n_pass++;
  endtask

  task automatic test_psdone_timeout();
    int n;
    check_move("pre_timeout", 3);
    withhold = 1'b1;
    clr_counts();
    phase_target = PSW'(6);
    phase_req = 1'b1;
    n = 0;
    while (!mmcm_psen && n < 10) begin
      tick();
      n++;
    end
    n = 0;
    while (!fault && n < 60) begin
      tick();
      n++;
    end
    phase_req = 1'b0;
    n_chk++;
    if (n != PTMO + 1) $display("FAIL psdone_timeout_time: got %0d cycles, required %0d", n, PTMO + 1);
    else n_pass++;
    n_chk++;
    if (phase_ack !== 1'b1 || phase_err !== 1'b1 || ready !== 1'b0 || mmcm_rst !== 1'b1 || cur_i() != model_cur)
      $display("FAIL psdone_timeout_state: ack=%b err=%b ready=%b rst=%b cur=%0d, required 1 1 0 1 %0d",
               phase_ack, phase_err, ready, mmcm_rst, cur_i(), model_cur);
    else n_pass++;
    withhold = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    model_cur = 0;
    n_chk++;
    if (phase_cur !== '0 || fault !== 1'b0)
      $display("FAIL restart_clears_phase: cur=%0d fault=%b, required 0 0", cur_i(), fault);
    else n_pass++;
  endtask

  task automatic test_restart_vs_lockloss();
    int n;
    wait_ready(80, n);
    check_move("pre_restart", 4);
    clr_counts();
    mmcm_locked = 1'b0;
    repeat (2) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n_chk++;
    if (lock_lost !== 1'b0 || mmcm_rst !== 1'b1 || phase_cur !== '0 || retry_cnt !== 2'd0)
      $display("FAIL restart_priority: lost=%b rst=%b cur=%0d retry=%0d, required 0 1 0 0", lock_lost, mmcm_rst, cur_i(), retry_cnt);
    else n_pass++;
    repeat (4) tick();
    n_chk++;
    if (lost_cnt != 0) $display("FAIL restart_no_lostpulse: got %0d pulses, required 0", lost_cnt);
    else n_pass++;
    model_cur = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    prev_cur = '0;
    since_psen = 100;
    gap_bad = 0;
    test_reset();
    test_bringup();
    test_lock_timeout();
    test_phase_steps();
    test_equal_target();
    test_random_moves();
    test_lock_loss();
    test_psdone_timeout();
    test_restart_vs_lockloss();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
